// File: rtl/ram_pkg.sv
// Shared types and constants for the byte-enabled synchronous RAM family.
package ram_pkg;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_t;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_ADDR_WIDTH = 5;

   function automatic int be_count(input int data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Read result register chain: 1 or 2 stages of {valid, data}.
// Data stages only load on a valid result, so the output holds between reads.
module ram_rd_pipe #(
   parameter int DATA_WIDTH = 32,
   parameter int STAGES     = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   output logic [DATA_WIDTH-1:0] out_data
);

   logic [STAGES-1:0]     valid_reg;
   logic [DATA_WIDTH-1:0] data_reg [STAGES];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_reg <= '0;
         for (int s = 0; s < STAGES; s++) begin
            data_reg[s] <= '0;
         end
      end else begin
         valid_reg[0] <= in_valid;
         if (in_valid) begin
            data_reg[0] <= in_data;
         end
         for (int s = 1; s < STAGES; s++) begin
            valid_reg[s] <= valid_reg[s-1];
            if (valid_reg[s-1]) begin
               data_reg[s] <= data_reg[s-1];
            end
         end
      end
   end

   assign out_valid = valid_reg[STAGES-1];
   assign out_data  = data_reg[STAGES-1];

endmodule

// File: rtl/ram_sync_be.sv
// Single-port synchronous RAM with byte write enables, 1/2-cycle read latency
// and an optional zeroing sweep after reset.
module ram_sync_be
   import ram_pkg::*;
#(
   parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
   parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter int READ_LATENCY   = 1,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            ena,
   input  logic                            wena,
   input  logic [ADDR_WIDTH-1:0]           addr,
   input  logic [be_count(DATA_WIDTH)-1:0] be,
   input  logic [DATA_WIDTH-1:0]           wdata,
   output logic [DATA_WIDTH-1:0]           rdata,
   output logic                            rvalid,
   output logic                            busy
);

   localparam int                    DEPTH       = 2 ** ADDR_WIDTH;
   localparam int                    BE_W        = be_count(DATA_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = ADDR_WIDTH'(DEPTH - 1);
   localparam state_t                RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;

   generate
      if ((DATA_WIDTH % 8) != 0 || !(READ_LATENCY == 1 || READ_LATENCY == 2)) begin : g_param_err
         $fatal(1, "ram_sync_be: DATA_WIDTH must be a multiple of 8 and READ_LATENCY 1 or 2");
      end
   endgenerate

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   state_t                state_reg, state_next;
   logic [ADDR_WIDTH-1:0] cnt_reg, cnt_next;
   logic                  arm_reg;
   logic                  clear_we;
   logic                  wr_req;
   logic                  rd_req;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic [BE_W-1:0]       wr_be;

   // arm_reg goes high one edge after reset release, so user writes never
   // reach the array while rst is held.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= RESET_STATE;
         cnt_reg   <= '0;
         arm_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         arm_reg   <= 1'b1;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      clear_we   = 1'b0;
      wr_req     = 1'b0;
      rd_req     = 1'b0;
      case (state_reg)
         ST_CLEAR: begin
            clear_we = 1'b1;
            cnt_next = cnt_reg + 1'b1;
            if (cnt_reg == LAST_ADDR) begin
               state_next = ST_READY;
            end
         end
         ST_READY: begin
            wr_req = ena & wena & arm_reg;
            rd_req = ena & ~wena;
         end
         default: state_next = RESET_STATE;
      endcase
   end

   assign busy = (state_reg == ST_CLEAR);

   // The sweep and user writes share the single write port.
   assign wr_addr = clear_we ? cnt_reg : addr;
   assign wr_data = clear_we ? '0 : wdata;
   assign wr_be   = clear_we ? '1 : (wr_req ? be : '0);

   always_ff @(posedge clk) begin
      for (int b = 0; b < BE_W; b++) begin
         if (wr_be[b]) begin
            mem[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
         end
      end
   end

   ram_rd_pipe #(
      .DATA_WIDTH (DATA_WIDTH),
      .STAGES     (READ_LATENCY)
   ) u_rd_pipe (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (rd_req),
      .in_data   (mem[addr]),
      .out_valid (rvalid),
      .out_data  (rdata)
   );

endmodule

// File: tb/tb_ram_sync_be.sv
// Directed bench driving a latency-1 and a latency-2 instance with identical stimulus.
module tb_ram_sync_be;

   logic        clk;
   logic        rst;
   logic        ena;
   logic        wena;
   logic [4:0]  addr;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic [31:0] rdata1, rdata2;
   logic        rvalid1, rvalid2;
   logic        busy1, busy2;

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [4:0]  qa [$];
   logic [31:0] qe [$];
   logic [31:0] last_exp;

   typedef struct {
      logic [4:0]  addr;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [10];

   ram_sync_be #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) u_l1 (
      .clk(clk), .rst(rst), .ena(ena), .wena(wena), .addr(addr), .be(be),
      .wdata(wdata), .rdata(rdata1), .rvalid(rvalid1), .busy(busy1)
   );

   ram_sync_be #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .READ_LATENCY(2), .CLEAR_ON_RESET(1)) u_l2 (
      .clk(clk), .rst(rst), .ena(ena), .wena(wena), .addr(addr), .be(be),
      .wdata(wdata), .rdata(rdata2), .rvalid(rvalid2), .busy(busy2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic logic [31:0] pat(input int k);
      return 32'h1 << (4 * (k % 8));
   endfunction

   // Release reset and run the sweep while trying writes then reads.
   task automatic run_clear(input string tag);
      int   n;
      logic saw;
      n   = 0;
      saw = 1'b0;
      rst = 1'b0;
      while (busy1 && n < 100) begin
         ena = 1'b1;
         if (n < 16) begin
            wena = 1'b1; addr = 5'd0; be = 4'hF; wdata = 32'hDEADBEEF;
         end else begin
            wena = 1'b0; addr = 5'(n); be = 4'h0;
         end
         step();
         n++;
         if (rvalid1 || rvalid2) saw = 1'b1;
      end
      ena = 1'b0; wena = 1'b0;
      check({tag, "_busy_cycles"}, 32'(n), 32'd32);
      check({tag, "_no_rvalid"}, {31'd0, saw}, 32'd0);
      check({tag, "_busy2_low"}, {31'd0, busy2}, 32'd0);
      $display("clear %s: busy cycles=%0d", tag, n);
   endtask

   task automatic write(input logic [4:0] a, input logic [3:0] b, input logic [31:0] d);
      ena = 1'b1; wena = 1'b1; addr = a; be = b; wdata = d;
      step();
      ena = 1'b0; wena = 1'b0;
      check("wr_rvalid1", {31'd0, rvalid1}, 32'd0);
      check("wr_rvalid2", {31'd0, rvalid2}, 32'd0);
      $display("write addr=%0d be=%h data=%h", a, b, d);
   endtask

   // Issue back-to-back reads from qa, expect qe on both latencies, then idle/hold.
   task automatic read_burst();
      int n;
      n = qa.size();
      for (int i = 0; i <= n + 1; i++) begin
         if (i < n) begin
            ena = 1'b1; wena = 1'b0; addr = qa[i]; be = 4'hF;
         end else begin
            ena = 1'b0;
         end
         step();
         if (i < n) begin
            check("rd1_valid", {31'd0, rvalid1}, 32'd1);
            check("rd1_data", rdata1, qe[i]);
            $display("read addr=%0d rdata1=%h exp=%h", qa[i], rdata1, qe[i]);
         end else begin
            check("rd1_idle", {31'd0, rvalid1}, 32'd0);
            check("rd1_hold", rdata1, qe[n-1]);
         end
         if (i >= 1 && i <= n) begin
            check("rd2_valid", {31'd0, rvalid2}, 32'd1);
            check("rd2_data", rdata2, qe[i-1]);
         end else begin
            check("rd2_idle", {31'd0, rvalid2}, 32'd0);
            if (i > n) check("rd2_hold", rdata2, qe[n-1]);
         end
      end
      last_exp = qe[n-1];
   endtask

   initial begin
      rst = 1'b1; ena = 1'b0; wena = 1'b0; addr = '0; be = '0; wdata = '0;
      last_exp = '0;
      step();
      step();
      check("rst_rvalid1", {31'd0, rvalid1}, 32'd0);
      check("rst_rvalid2", {31'd0, rvalid2}, 32'd0);
      check("rst_rdata1", rdata1, 32'd0);
      check("rst_rdata2", rdata2, 32'd0);
      check("rst_busy1", {31'd0, busy1}, 32'd1);
      check("rst_busy2", {31'd0, busy2}, 32'd1);

      run_clear("init");

      // Every word zero after the sweep, including addr 0 written during it.
      qa.delete(); qe.delete();
      for (int k = 0; k < 32; k++) begin qa.push_back(5'(k)); qe.push_back(32'd0); end
      read_burst();

      // Full write/readback of the walking-nibble pattern.
      for (int k = 0; k < 32; k++) write(5'(k), 4'hF, pat(k));
      qa.delete(); qe.delete();
      for (int k = 0; k < 32; k++) begin qa.push_back(5'(k)); qe.push_back(pat(k)); end
      read_burst();

      vecs[0] = '{5'd3,  4'hF,    32'hAABBCCDD, 32'hAABBCCDD};
      vecs[1] = '{5'd3,  4'b0101, 32'h11223344, 32'hAA22CC44};
      vecs[2] = '{5'd3,  4'h0,    32'hFFFFFFFF, 32'hAA22CC44};
      vecs[3] = '{5'd3,  4'h8,    32'h99000000, 32'h9922CC44};
      vecs[4] = '{5'd31, 4'hF,    32'h12345678, 32'h12345678};
      vecs[5] = '{5'd31, 4'h2,    32'h0000AB00, 32'h1234AB78};
      vecs[6] = '{5'd0,  4'h1,    32'h000000EE, 32'h000000EE};
      vecs[7] = '{5'd5,  4'hF,    32'h00000005, 32'h00000005};
      vecs[8] = '{5'd6,  4'hF,    32'h00000006, 32'h00000006};
      vecs[9] = '{5'd7,  4'hF,    32'h00000007, 32'h00000007};

      // Write then read the next cycle; a write must leave rdata untouched.
      for (int v = 0; v < 10; v++) begin
         write(vecs[v].addr, vecs[v].be, vecs[v].wdata);
         check("wr_hold1", rdata1, last_exp);
         check("wr_hold2", rdata2, last_exp);
         qa.delete(); qe.delete();
         qa.push_back(vecs[v].addr); qe.push_back(vecs[v].exp);
         read_burst();
      end

      // Pipelined reads 5,6,7.
      qa.delete(); qe.delete();
      qa.push_back(5'd5); qa.push_back(5'd6); qa.push_back(5'd7);
      qe.push_back(32'd5); qe.push_back(32'd6); qe.push_back(32'd7);
      read_burst();

      // Reset while a latency-2 read is in flight.
      ena = 1'b1; wena = 1'b0; addr = 5'd5;
      step();
      ena = 1'b0;
      rst = 1'b1;
      #1;
      check("mid_rvalid2", {31'd0, rvalid2}, 32'd0);
      check("mid_rdata2", rdata2, 32'd0);
      check("mid_rdata1", rdata1, 32'd0);
      check("mid_busy1", {31'd0, busy1}, 32'd1);
      step();
      check("mid_rvalid2_late", {31'd0, rvalid2}, 32'd0);
      check("mid_rdata2_late", rdata2, 32'd0);
      step();
      $display("mid-read reset applied");
      run_clear("rerst");

      qa.delete(); qe.delete();
      qa.push_back(5'd0); qa.push_back(5'd5); qa.push_back(5'd31);
      qe.push_back(32'd0); qe.push_back(32'd0); qe.push_back(32'd0);
      read_burst();

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
